// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the MIPS trace capture block.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int CH_PC   = 0;
  localparam int CH_ULA  = 1;
  localparam int CH_DMEM = 2;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mips_trace_buffer_ram.sv
// Simple dual-port trace storage: synchronous write, registered read, no reset.
module trace_ram
  import mips_trace_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 64,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mips_trace_buffer.sv
// Circular trace capture with PC-match / forced trigger and post-trigger window.
// Optional per-entry timestamps when TRACE_TIMESTAMP_EN is defined (adds rd_ts).
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH   = 3,
  parameter int DEPTH  = 64,
  parameter int TS_W   = 16,
  localparam int AW    = addr_width(DEPTH),
  localparam int SW    = N_CH * DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SW-1:0]     ch_data,
  input  logic              ch_valid,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic              force_trig,
  input  logic [AW:0]       post_count,
  output logic [1:0]        state_out,
  output logic              triggered,
  output logic              done,
  output logic [AW:0]       count_out,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_valid,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]   rd_ts,
`endif
  output logic [SW-1:0]     rd_data
);

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int TS_BITS = TS_EN ? TS_W : 0;
  localparam int RAM_W   = SW + TS_BITS;

  trace_state_e        state, state_nx;
  logic [AW-1:0]       wr_ptr;
  logic [AW:0]         count, remaining;
  logic                force_pend;
  logic                rd_hit;
  logic [DATA_W-1:0]   pc_ch;
  logic                capture, trig_hit, rd_fire, in_range;
  logic [AW-1:0]       rd_idx;
  logic [RAM_W-1:0]    ram_wdata, ram_q;

  assign pc_ch    = ch_data[CH_PC*DATA_W +: DATA_W];
  // arm outranks everything: the arm cycle neither stores nor triggers.
  assign capture  = ch_valid && !arm && (state == ST_ARMED || state == ST_POST);
  assign trig_hit = (state == ST_ARMED) && ch_valid && !arm &&
                    ((trig_en && pc_ch == trig_pc) || force_trig || force_pend);

  always_comb begin
    state_nx = state;
    if (arm) begin
      state_nx = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED: if (trig_hit) state_nx = (post_count == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (capture && remaining == (AW+1)'(1)) state_nx = ST_DONE;
        default:  state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      count      <= '0;
      remaining  <= '0;
      triggered  <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (arm) begin
        wr_ptr     <= '0;
        count      <= '0;
        remaining  <= '0;
        triggered  <= 1'b0;
        force_pend <= 1'b0;
      end else begin
        if (capture) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count != (AW+1)'(DEPTH)) count <= count + 1'b1;
        end
        if (trig_hit) begin
          triggered  <= 1'b1;
          remaining  <= post_count;
          force_pend <= 1'b0;
        end else if (state == ST_POST && capture) begin
          remaining <= remaining - 1'b1;
        end else if (state == ST_ARMED && force_trig && !ch_valid) begin
          force_pend <= 1'b1;
        end
      end
    end
  end

  // rd_req is a single-cycle request with no backpressure; accepted only in
  // DONE, answered by rd_valid exactly one cycle later, one per cycle.
  assign rd_fire  = rd_req && (state == ST_DONE);
  assign in_range = {1'b0, rd_addr} < count;
  assign rd_idx   = wr_ptr - count[AW-1:0] + rd_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_hit   <= rd_fire && in_range;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clock) begin
    if (reset || arm) ts_cnt <= '0;
    else if (ch_valid) ts_cnt <= ts_cnt + 1'b1;
  end

  assign ram_wdata = {ts_cnt, ch_data};
  assign rd_ts     = rd_hit ? ram_q[SW +: TS_W] : '0;
`else
  assign ram_wdata = ch_data;
`endif

  assign rd_data   = rd_hit ? ram_q[SW-1:0] : '0;
  assign state_out = state;
  assign done      = (state == ST_DONE);
  assign count_out = count;

  trace_ram #(.WIDTH(RAM_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock (clock),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (ram_wdata),
    .re    (rd_fire),
    .raddr (rd_idx),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer (DEPTH=8); rd_ts checks only with TRACE_TIMESTAMP_EN.
module tb_mips_trace_buffer;

  localparam int DATA_W = 32;
  localparam int N_CH   = 3;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;
  localparam int AW     = 3;
  localparam int SW     = N_CH * DATA_W;
  localparam int EW     = SW + TS_W + 1;

  logic              clock, reset;
  logic [SW-1:0]     ch_data;
  logic              ch_valid, arm, trig_en, force_trig;
  logic [DATA_W-1:0] trig_pc;
  logic [AW:0]       post_count;
  logic [1:0]        state_out;
  logic              triggered, done;
  logic [AW:0]       count_out;
  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid;
  logic [SW-1:0]     rd_data;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   rd_ts;
`endif

  int total = 0;
  int bad   = 0;
  logic want_valid = 1'b0;
  logic [EW-1:0] exp_q[$];

  mips_trace_buffer #(.DATA_W(DATA_W), .N_CH(N_CH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clock(clock), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .force_trig(force_trig),
    .post_count(post_count), .state_out(state_out), .triggered(triggered),
    .done(done), .count_out(count_out), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(rd_ts),
`endif
    .rd_data(rd_data)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [SW-1:0] mk(input logic [31:0] pc);
    return {~pc, pc ^ 32'h5555_0000, pc};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock; pulses drop afterwards and any read response is scored.
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge clock);
    #1;
    chk("rd_valid", rd_valid, want_valid);
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_extra: got response, want none");
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e[SW-1:0]);
`ifdef TRACE_TIMESTAMP_EN
        if (e[EW-1]) chk("rd_ts", rd_ts, e[SW +: TS_W]);
`endif
      end
    end
    want_valid = 1'b0;
    arm = 1'b0; force_trig = 1'b0; ch_valid = 1'b0; rd_req = 1'b0;
  endtask

  // driver tasks
  task automatic sample(input logic [31:0] pc, input logic v, input logic frc);
    ch_data = mk(pc); ch_valid = v; force_trig = frc;
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
  endtask

  task automatic read_req(input logic [AW-1:0] a, input logic [SW-1:0] d,
                          input logic [TS_W-1:0] ts, input logic ts_chk);
    rd_req = 1'b1; rd_addr = a; want_valid = 1'b1;
    exp_q.push_back({ts_chk, ts, d});
    tick();
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  st;
    logic        trg;
    logic [AW:0] cnt;
  } vec_t;
  vec_t vt[19];

  initial begin
    reset = 1'b1; ch_data = '0; ch_valid = 0; arm = 0; trig_en = 0; trig_pc = '0;
    force_trig = 0; post_count = '0; rd_req = 0; rd_addr = '0;

    // 1: reset
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", state_out, 2'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count_out, 4'd0);
    chk("rst_trig", triggered, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    rd_req = 1'b1; rd_addr = 3'd0;
    tick();
    chk("idle_state", state_out, 2'd0);

    // 2: wrap and read-back, table-driven
    for (int i = 0; i < 19; i++) begin
      vt[i].pc  = 32'(4 * i);
      vt[i].st  = (i < 16) ? 2'd1 : (i < 18) ? 2'd2 : 2'd3;
      vt[i].trg = (i >= 16);
      vt[i].cnt = (i + 1 > 8) ? 4'd8 : 4'(i + 1);
    end
    trig_en = 1'b1; trig_pc = 32'h40; post_count = 4'd2;
    do_arm();
    chk("arm_state", state_out, 2'd1);
    for (int i = 0; i < 19; i++) begin
      sample(vt[i].pc, 1'b1, 1'b0);
      chk($sformatf("wrap_state[%0d]", i), state_out, vt[i].st);
      chk($sformatf("wrap_trig[%0d]", i), triggered, vt[i].trg);
      chk($sformatf("wrap_cnt[%0d]", i), count_out, vt[i].cnt);
    end
    chk("wrap_done", done, 1'b1);
    for (int a = 0; a < 8; a++) read_req(3'(a), mk(32'h2C + 32'(4 * a)), '0, 1'b0);

    // 3: immediate DONE and pending force
    trig_en = 1'b0; post_count = 4'd0;
    do_arm();
    sample(32'h100, 1'b1, 1'b0);
    sample(32'h104, 1'b1, 1'b0);
    sample(32'h108, 1'b1, 1'b1);
    chk("imm_state", state_out, 2'd3);
    chk("imm_count", count_out, 4'd3);
    read_req(3'd0, mk(32'h100), 16'd0, 1'b1);
    read_req(3'd1, mk(32'h104), 16'd1, 1'b1);
    read_req(3'd2, mk(32'h108), 16'd2, 1'b1);
    read_req(3'd3, '0, 16'd0, 1'b1);
    do_arm();
    sample(32'h200, 1'b1, 1'b0);
    sample(32'h0, 1'b0, 1'b1);
    chk("pend_state", state_out, 2'd1);
    sample(32'h204, 1'b1, 1'b0);
    chk("pend_fire", state_out, 2'd3);
    chk("pend_count", count_out, 4'd2);
    read_req(3'd1, mk(32'h204), 16'd1, 1'b1);

    // 4: gaps, then re-arm during POST
    post_count = 4'd1;
    do_arm();
    sample(32'h300, 1'b1, 1'b0);
    sample(32'h304, 1'b0, 1'b0);
    sample(32'h308, 1'b1, 1'b0);
    sample(32'h30C, 1'b0, 1'b0);
    chk("gap_count", count_out, 4'd2);
    sample(32'h310, 1'b1, 1'b1);
    chk("gap_post", state_out, 2'd2);
    sample(32'h314, 1'b1, 1'b0);
    chk("gap_done", state_out, 2'd3);
    chk("gap_count2", count_out, 4'd4);
    read_req(3'd0, mk(32'h300), '0, 1'b0);
    read_req(3'd1, mk(32'h308), '0, 1'b0);
    read_req(3'd2, mk(32'h310), '0, 1'b0);
    read_req(3'd3, mk(32'h314), '0, 1'b0);
    trig_en = 1'b1; trig_pc = 32'h400; post_count = 4'd4;
    do_arm();
    sample(32'h3F0, 1'b1, 1'b0);
    sample(32'h400, 1'b1, 1'b0);
    sample(32'h404, 1'b1, 1'b0);
    chk("rearm_pre", state_out, 2'd2);
    do_arm();
    chk("rearm_state", state_out, 2'd1);
    chk("rearm_count", count_out, 4'd0);
    chk("rearm_trig", triggered, 1'b0);

    // 5: arm beats trigger, then reset mid-POST
    arm = 1'b1;
    sample(32'h400, 1'b1, 1'b0);
    chk("armtrig_state", state_out, 2'd1);
    chk("armtrig_trig", triggered, 1'b0);
    chk("armtrig_count", count_out, 4'd0);
    sample(32'h400, 1'b1, 1'b0);
    sample(32'h404, 1'b1, 1'b0);
    chk("mid_post", state_out, 2'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_state", state_out, 2'd0);
    chk("rst2_trig", triggered, 1'b0);
    chk("rst2_done", done, 1'b0);
    chk("rst2_count", count_out, 4'd0);
    chk("rst2_data", rd_data, '0);

`ifdef TRACE_TIMESTAMP_EN
    // 6: timestamps across a gap
    trig_en = 1'b0; post_count = 4'd0;
    do_arm();
    sample(32'h500, 1'b1, 1'b0);
    sample(32'h504, 1'b1, 1'b0);
    sample(32'h0, 1'b0, 1'b0);
    sample(32'h0, 1'b0, 1'b0);
    sample(32'h508, 1'b1, 1'b0);
    sample(32'h50C, 1'b1, 1'b0);
    sample(32'h510, 1'b1, 1'b1);
    chk("ts_done", state_out, 2'd3);
    for (int a = 0; a < 5; a++) read_req(3'(a), mk(32'h500 + 32'(4 * a)), 16'(a), 1'b1);
    read_req(3'd5, '0, 16'd0, 1'b1);
`endif

    tick();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL rd_missing: got %0d outstanding, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
On-chip, parametrised trace capture for the MIPS core. Samples N_CH observation channels (channel 0 = PC, 1 = ULA result, 2 = data-memory output) into a circular buffer of DEPTH entries. A PC-match or forced trigger freezes the buffer after a programmable number of post-trigger samples. Sits beside mips_top; the captured window is read back via a registered read port for debug and bench checking.

Parameters:
DATA_W, 32, width of each channel.
N_CH, 3, number of channels; channel 0 is always the PC used for triggering.
DEPTH, 64, buffer entries; power of two, >= 4.
TS_W, 16, timestamp width; used only with TRACE_TIMESTAMP_EN.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
ch_data  in  N_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
ch_valid  in  1  sample qualifier; a sample is taken only when high.
arm  in  1  single-cycle pulse; starts a new capture.
trig_en  in  1  enables the PC-match trigger.
trig_pc  in  DATA_W  PC value to match against channel 0.
force_trig  in  1  unconditional trigger while ARMED.
post_count  in  AW+1  post-trigger samples; sampled when the trigger fires. AW = clog2(DEPTH).
state_out  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
triggered  out  1  high from the trigger cycle until the next arm or reset.
done  out  1  equals (state_out == DONE).
count_out  out  AW+1  valid entries, saturating at DEPTH.
rd_req  in  1  readout request.
rd_addr  in  AW  entry index; 0 = oldest entry.
rd_valid  out  1  read response strobe.
rd_data  out  N_CH*DATA_W  read response data.

Behaviour:
- Reset values: state IDLE; all outputs 0; wr_ptr, count and post counter 0. RAM contents are not reset; reads are gated by count.
- IDLE: nothing is stored; arm moves to ARMED.
- ARMED:
  - On arm, wr_ptr and count clear; capture starts the next cycle. The arm cycle stores nothing.
  - Each ch_valid cycle writes ch_data at wr_ptr. wr_ptr wraps modulo DEPTH. count saturates at DEPTH, so the oldest entry is overwritten.
- Trigger: in ARMED on a ch_valid cycle when (trig_en && ch0 == trig_pc) || force_trig.
  - The triggering sample is stored.
  - triggered is set and remaining = post_count.
  - If post_count == 0, go straight to DONE; otherwise go to POST.
  - force_trig without ch_valid is held internally as pending and fires on the next ch_valid.
- POST:
  - Each ch_valid cycle stores a sample and decrements remaining.
  - When the sample with remaining == 1 is stored, go to DONE.
  - Further trigger conditions are ignored.
- DONE: the buffer is frozen; no writes occur.
- Readout:
  - Serviced only in DONE. rd_req in cycle N gives rd_valid = 1 in cycle N+1.
  - rd_data = RAM[(wr_ptr - count + rd_addr) mod DEPTH].
  - If rd_addr >= count, rd_data is all zeros and rd_valid is still 1.
  - rd_req outside DONE is ignored; rd_valid stays 0.
  - Back-to-back requests are accepted every cycle.
- arm in any state, including POST or DONE, restarts the capture. arm outranks a trigger in the same cycle, and that sample is not stored.
- reset asserted mid-capture or mid-read returns every block state to its reset values the next cycle.
- If post_count > DEPTH, capture continues until remaining reaches 0. Only the last DEPTH samples survive.

Optional Feature:
TRACE_TIMESTAMP_EN:
- Defined: adds a TS_W counter of ch_valid cycles since the last arm. It wraps and clears on arm. Each entry stores the counter value alongside the sample, and an extra output rd_ts [TS_W] is returned with the same timing as rd_data (zero when out of range).
- Undefined: no counter, no storage for it, and no rd_ts port.

Decomposition:
- Package mips_trace_pkg holds:
  - the state enum (IDLE/ARMED/POST/DONE) and its 2-bit encoding;
  - a helper function for AW;
  - channel index constants CH_PC=0, CH_ULA=1, CH_DMEM=2.
- Sub-module trace_ram: simple dual-port RAM, DEPTH x width, synchronous write, 1-cycle registered read, no reset. Control, pointers and the FSM stay in mips_trace_buffer.

Test Plan:
1. Reset check: reset held 2 cycles. After reset, state_out=0, done=0, count_out=0 and rd_valid=0; rd_req in IDLE gives no rd_valid.
2. Wrap and read-back: DEPTH=8, trig_en=1, trig_pc=0x40, post_count=2; arm, then feed PC=0x00,0x04,...,0x48 (step 4).
   - Trigger fires at 0x40; DONE after 0x48.
   - count_out=8; reading addr 0..7 returns PC 0x2C..0x48 with rd_valid one cycle after each rd_req.
3. Immediate DONE: post_count=0, force_trig pulsed with ch_valid on the 3rd sample -> DONE that cycle, count_out=3, addr 3 reads all zeros.
4. Gaps and re-arm: ch_valid toggling 1,0,1,0 -> only the valid samples are stored; arm issued during POST -> count_out=0, triggered=0, state ARMED.
5. arm vs trigger: arm and a matching PC in the same cycle -> nothing stored and triggered stays 0. Then a reset pulse mid-POST -> all outputs 0 the next cycle.
6. With TRACE_TIMESTAMP_EN: arm, 5 valid samples with a 2-cycle gap, trigger on the last -> rd_ts reads 0,1,2,3,4.
